// File: rtl/dma_line_bridge_if.sv
// dma_line_bridge_if: bundles the control, host DMA FIFO and local memory signals of
// dma_line_bridge.
//   master : environment side. It drives the go/mode/num_lines/base_addr command, the
//            FIFO status and read head, and the memory read returns.
//   slave  : bridge side. It drives busy/done, the FIFO pops and pushes, and the memory
//            requests.
interface dma_line_bridge_if #(
   parameter int unsigned LINE_WIDTH     = 512,
   parameter int unsigned WORD_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 28,
   parameter int unsigned LINE_CNT_WIDTH = 16
) ();
   // command / status
   logic                      go;
   logic                      mode;
   logic [LINE_CNT_WIDTH-1:0] num_lines;
   logic [ADDR_WIDTH-1:0]     base_addr;
   logic                      busy;
   logic                      done;
   // host DMA FIFOs
   logic                      dma_empty;
   logic [LINE_WIDTH-1:0]     dma_rd_data;
   logic                      dma_rd_en;
   logic                      dma_full;
   logic [LINE_WIDTH-1:0]     dma_wr_data;
   logic                      dma_wr_en;
   // local memory controller
   logic                      mem_en;
   logic                      mem_wr_en;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic [WORD_WIDTH-1:0]     mem_wr_data;
   logic [WORD_WIDTH-1:0]     mem_rd_data;
   logic                      mem_rd_valid;

   modport master (
      output go, mode, num_lines, base_addr, dma_empty, dma_rd_data, dma_full,
             mem_rd_data, mem_rd_valid,
      input  busy, done, dma_rd_en, dma_wr_data, dma_wr_en, mem_en, mem_wr_en, mem_addr,
             mem_wr_data
   );

   modport slave (
      input  go, mode, num_lines, base_addr, dma_empty, dma_rd_data, dma_full,
             mem_rd_data, mem_rd_valid,
      output busy, done, dma_rd_en, dma_wr_data, dma_wr_en, mem_en, mem_wr_en, mem_addr,
             mem_wr_data
   );
endinterface

// File: rtl/dma_line_bridge.sv
// dma_line_bridge: moves whole cache lines between the host DMA FIFOs and a word-wide
// memory port.
//   Load  (mode 0): pop one line from the DMA read FIFO and write it out as WORDS words.
//   Store (mode 1): read WORDS words from memory, gather them, and push the line to the
//                   DMA write FIFO.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  dma_line_bridge_if.slave. It carries the command/status, the FIFO and the
//        memory signals.
// Build option:
//   DMA_LINE_BRIDGE_PIPELINED_READ_EN  When defined, store mode issues all WORDS reads of
//   a line back-to-back and fills slots from an in-order return counter. Otherwise it
//   keeps one read outstanding at a time.
module dma_line_bridge #(
   parameter int unsigned LINE_WIDTH     = 512,
   parameter int unsigned WORD_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 28,
   parameter int unsigned LINE_CNT_WIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   dma_line_bridge_if.slave bus
);
   localparam int unsigned WORDS = LINE_WIDTH / WORD_WIDTH;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORDS - 1);

   // The transfer direction is carried by which state branch IDLE takes, so mode needs no
   // register of its own.
   typedef enum logic [2:0] {
      StIdle, StLdFetch, StLdWrite, StStReq, StStWait, StStPush, StDone
   } state_e;

   state_e                               state_q, state_d;
   logic [LINE_CNT_WIDTH-1:0]            num_lines_q, num_lines_d;
   logic [ADDR_WIDTH-1:0]                base_q, base_d;
   logic [LINE_CNT_WIDTH-1:0]            line_idx_q, line_idx_d;
   logic [IDX_W-1:0]                     word_idx_q, word_idx_d;
   logic [WORDS-1:0][WORD_WIDTH-1:0]     buf_q, buf_d;
`ifdef DMA_LINE_BRIDGE_PIPELINED_READ_EN
   // Slot for the next read return. Returns arrive in issue order.
   logic [IDX_W-1:0]                     ret_idx_q, ret_idx_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         num_lines_q <= '0;
         base_q      <= '0;
         line_idx_q  <= '0;
         word_idx_q  <= '0;
         buf_q       <= '0;
      end else begin
         state_q     <= state_d;
         num_lines_q <= num_lines_d;
         base_q      <= base_d;
         line_idx_q  <= line_idx_d;
         word_idx_q  <= word_idx_d;
         buf_q       <= buf_d;
      end
   end

`ifdef DMA_LINE_BRIDGE_PIPELINED_READ_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ret_idx_q <= '0;
      end else begin
         ret_idx_q <= ret_idx_d;
      end
   end
`endif

   // The address is a pure function of the registered counters. It therefore reads 0
   // straight out of reset, and it wraps modulo 2^ADDR_WIDTH.
   assign bus.mem_addr    = base_q
                          + ADDR_WIDTH'(line_idx_q) * ADDR_WIDTH'(WORDS)
                          + ADDR_WIDTH'(word_idx_q);
   assign bus.mem_wr_data = buf_q[word_idx_q];
   assign bus.dma_wr_data = buf_q;

   always_comb begin
      state_d       = state_q;
      num_lines_d   = num_lines_q;
      base_d        = base_q;
      line_idx_d    = line_idx_q;
      word_idx_d    = word_idx_q;
      buf_d         = buf_q;
`ifdef DMA_LINE_BRIDGE_PIPELINED_READ_EN
      ret_idx_d     = ret_idx_q;
`endif
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.dma_rd_en = 1'b0;
      bus.dma_wr_en = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_wr_en = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.go) begin
               num_lines_d = bus.num_lines;
               base_d      = bus.base_addr;
               line_idx_d  = '0;
               word_idx_d  = '0;
`ifdef DMA_LINE_BRIDGE_PIPELINED_READ_EN
               ret_idx_d   = '0;
`endif
               if (bus.num_lines == '0) begin
                  state_d = StDone;
               end else if (bus.mode) begin
                  state_d = StStReq;
               end else begin
                  state_d = StLdFetch;
               end
            end
         end

         StLdFetch: begin
            bus.busy = 1'b1;
            if (!bus.dma_empty) begin
               bus.dma_rd_en = 1'b1;
               buf_d         = bus.dma_rd_data;
               state_d       = StLdWrite;
            end
         end

         StLdWrite: begin
            bus.busy      = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_wr_en = 1'b1;
            if (word_idx_q == LastIdx) begin
               word_idx_d = '0;
               line_idx_d = line_idx_q + LINE_CNT_WIDTH'(1);
               state_d    = (line_idx_d == num_lines_q) ? StDone : StLdFetch;
            end else begin
               word_idx_d = word_idx_q + IDX_W'(1);
            end
         end

`ifdef DMA_LINE_BRIDGE_PIPELINED_READ_EN
         // Issue one read per cycle. Returns may already arrive while the burst is
         // still being issued.
         StStReq: begin
            bus.busy   = 1'b1;
            bus.mem_en = 1'b1;
            if (bus.mem_rd_valid) begin
               buf_d[ret_idx_q] = bus.mem_rd_data;
               ret_idx_d        = ret_idx_q + IDX_W'(1);
            end
            if (word_idx_q == LastIdx) begin
               state_d = StStWait;
            end else begin
               word_idx_d = word_idx_q + IDX_W'(1);
            end
         end

         StStWait: begin
            bus.busy = 1'b1;
            if (bus.mem_rd_valid) begin
               buf_d[ret_idx_q] = bus.mem_rd_data;
               if (ret_idx_q == LastIdx) begin
                  ret_idx_d  = '0;
                  word_idx_d = '0;
                  state_d    = StStPush;
               end else begin
                  ret_idx_d = ret_idx_q + IDX_W'(1);
               end
            end
         end
`else
         StStReq: begin
            bus.busy   = 1'b1;
            bus.mem_en = 1'b1;
            state_d    = StStWait;
         end

         StStWait: begin
            bus.busy = 1'b1;
            if (bus.mem_rd_valid) begin
               buf_d[word_idx_q] = bus.mem_rd_data;
               if (word_idx_q == LastIdx) begin
                  word_idx_d = '0;
                  state_d    = StStPush;
               end else begin
                  word_idx_d = word_idx_q + IDX_W'(1);
                  state_d    = StStReq;
               end
            end
         end
`endif

         StStPush: begin
            bus.busy = 1'b1;
            if (!bus.dma_full) begin
               bus.dma_wr_en = 1'b1;
               line_idx_d    = line_idx_q + LINE_CNT_WIDTH'(1);
               state_d       = (line_idx_d == num_lines_q) ? StDone : StStReq;
            end
         end

         StDone: begin
            bus.done = 1'b1;
            state_d  = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end
endmodule

// File: tb/tb_dma_line_bridge.sv
// Directed bench for dma_line_bridge. It covers reset, load, a load stall, store with
// back-pressure, zero lines, address wrap, and a reset in the middle of a transfer.
module tb_dma_line_bridge;
   localparam int unsigned LW = 512;
   localparam int unsigned WW = 32;
   localparam int unsigned AW = 28;
   localparam int unsigned CW = 16;
   localparam int unsigned NW = LW / WW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dma_line_bridge_if bus ();
   dma_line_bridge dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int t;
   int stall_lo   = -1;
   int stall_hi   = -1;
   int go_again_t = -1;

   logic [LW-1:0] fifo[$];
   logic [AW-1:0] wr_addr[$];
   logic [WW-1:0] wr_data[$];
   logic [LW-1:0] lines_out[$];

   int rd_en_cnt, wr_en_cnt, done_cnt, done_t, busy_cnt, en_cnt;
   int stall_viol, empty_viol, full_viol, ret_cnt, r16, first_push_t, full_left;
   bit full_arm = 1'b0;
   logic          rd_pend = 1'b0;
   logic [WW-1:0] rd_pend_data = '0;

   function automatic logic [WW-1:0] mem_val(logic [AW-1:0] a);
      return {4'h5, a};
   endfunction

   function automatic logic [LW-1:0] mk_line(logic [WW-1:0] b);
      logic [LW-1:0] l;
      for (int i = 0; i < NW; i++) l[i*WW +: WW] = b + WW'(i);
      return l;
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one cycle: drive the inputs at posedge+1, then sample the outputs at
   // posedge+2. The memory model returns each read one cycle after its request.
   task automatic cyc();
      @(posedge clk);
      #1;
      t++;
      bus.go           = (t == go_again_t);
      bus.dma_full     = (full_left > 0);
      if (full_left > 0) full_left--;
      bus.mem_rd_valid = rd_pend;
      bus.mem_rd_data  = rd_pend ? rd_pend_data : 32'hDEAD_BEEF;
      if (rd_pend) begin
         ret_cnt++;
         if (full_arm && ret_cnt == NW) begin
            full_arm  = 1'b0;
            full_left = 4;
            r16       = t;
         end
      end
      bus.dma_empty   = (fifo.size() == 0) || (t >= stall_lo && t <= stall_hi);
      bus.dma_rd_data = (fifo.size() != 0) ? fifo[0] : '0;
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
         done_cnt++;
         done_t = t;
      end
      if (bus.dma_rd_en | bus.dma_wr_en | bus.mem_en) en_cnt++;
      if (bus.dma_rd_en) begin
         rd_en_cnt++;
         if (bus.dma_empty) empty_viol++;
         else fifo.delete(0);
      end
      if (bus.dma_wr_en) begin
         wr_en_cnt++;
         if (bus.dma_full) full_viol++;
         lines_out.push_back(bus.dma_wr_data);
         if (first_push_t < 0) first_push_t = t;
      end
      if (t >= stall_lo && t <= stall_hi && (bus.mem_en | bus.dma_rd_en)) stall_viol++;
      rd_pend      = bus.mem_en & ~bus.mem_wr_en;
      rd_pend_data = mem_val(bus.mem_addr);
      if (bus.mem_en & bus.mem_wr_en) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wr_data);
      end
   endtask

   task automatic start(logic m, int n, logic [AW-1:0] b);
      wr_addr.delete();
      wr_data.delete();
      lines_out.delete();
      rd_en_cnt = 0; wr_en_cnt = 0; done_cnt = 0; busy_cnt = 0; en_cnt = 0;
      stall_viol = 0; empty_viol = 0; full_viol = 0; ret_cnt = 0;
      done_t = -1; r16 = -1; first_push_t = -1;
      bus.mode      = m;
      bus.num_lines = CW'(n);
      bus.base_addr = b;
      bus.go        = 1'b1;
      t             = 0;
      cyc();
   endtask

   task automatic run_to_done(int max, string tag);
      for (int i = 0; i < max && done_cnt == 0; i++) cyc();
      repeat (3) cyc();
      check({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   task automatic check_writes(string tag, int n, logic [AW-1:0] base, logic [WW-1:0] d0);
      check({tag, "_nwr"}, wr_addr.size(), n);
      for (int i = 0; i < wr_addr.size() && i < n; i++) begin
         check($sformatf("%s_addr%0d", tag, i), wr_addr[i], AW'(base + AW'(i)));
         check($sformatf("%s_data%0d", tag, i), wr_data[i], d0 + WW'(i));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst              = 1'b1;
      bus.go           = 1'b0;
      bus.mode         = 1'b0;
      bus.num_lines    = '0;
      bus.base_addr    = '0;
      bus.dma_empty    = 1'b1;
      bus.dma_rd_data  = '0;
      bus.dma_full     = 1'b0;
      bus.mem_rd_data  = '0;
      bus.mem_rd_valid = 1'b0;
      t = 0; full_left = 0; done_cnt = 0;
      repeat (3) cyc();
      check("reset_ctl", {bus.busy, bus.done, bus.dma_rd_en, bus.dma_wr_en, bus.mem_en,
                          bus.mem_wr_en}, 0);
      check("reset_addr", bus.mem_addr, 0);
      check("reset_line", |bus.dma_wr_data, 0);
      rst = 1'b0;
      cyc();

      // Load one line. The second go, issued mid-transfer, must be ignored.
      fifo.push_back(mk_line(32'hA000));
      go_again_t = 5;
      start(1'b0, 1, 28'h100);
      bus.mode = 1'b1; bus.num_lines = 16'd7; bus.base_addr = '0;
      run_to_done(60, "ld1");
      go_again_t = -1;
      check("ld1_done_t", done_t, 18);
      check("ld1_rd_en", rd_en_cnt, 1);
      check("ld1_busy", busy_cnt, 17);
      check_writes("ld1", 16, 28'h100, 32'hA000);

      // Load three lines, with the FIFO forced empty for 5 cycles before line 2.
      fifo.push_back(mk_line(32'hB000));
      fifo.push_back(mk_line(32'hB010));
      fifo.push_back(mk_line(32'hB020));
      stall_lo = 18; stall_hi = 22;
      start(1'b0, 3, 28'h0040000);
      run_to_done(120, "ld3");
      stall_lo = -1; stall_hi = -1;
      check("ld3_done_t", done_t, 57);
      check("ld3_rd_en", rd_en_cnt, 3);
      check("ld3_stall", stall_viol, 0);
      check("ld3_empty", empty_viol, 0);
      check_writes("ld3", 48, 28'h0040000, 32'hB000);

      // Store two lines. dma_full is held for 4 cycles once the first line is gathered.
      full_arm = 1'b1;
      start(1'b1, 2, 28'h2000);
      run_to_done(300, "st2");
      check("st2_wr_en", wr_en_cnt, 2);
      check("st2_full", full_viol, 0);
      check("st2_push_t", first_push_t, r16 + 5);
      check("st2_rd_en", rd_en_cnt, 0);
      check("st2_nlines", lines_out.size(), 2);
      for (int l = 0; l < lines_out.size() && l < 2; l++)
         for (int i = 0; i < NW; i++)
            check($sformatf("st2_l%0d_w%0d", l, i), lines_out[l][i*WW +: WW],
                  mem_val(AW'(28'h2000 + 16 * l + i)));

      // A transfer of zero lines.
      start(1'b0, 0, 28'h55);
      run_to_done(10, "zero");
      check("zero_done_t", done_t, 1);
      check("zero_en", en_cnt, 0);

      // Address wrap.
      fifo.push_back(mk_line(32'hE000));
      start(1'b0, 1, 28'hFFFFFF8);
      run_to_done(40, "wrap");
      check_writes("wrap", 16, 28'hFFFFFF8, 32'hE000);

      // Reset during word 7 of a load, then a clean restart with new arguments.
      fifo.push_back(mk_line(32'hC000));
      start(1'b0, 1, 28'h300);
      while (t < 9) cyc();
      check("rst_pre_addr", bus.mem_addr, 28'h307);
      rst = 1'b1;
      cyc();
      check("rst_ctl", {bus.busy, bus.done, bus.dma_rd_en, bus.dma_wr_en, bus.mem_en,
                        bus.mem_wr_en}, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_wdata", bus.mem_wr_data, 0);
      check("rst_line", |bus.dma_wr_data, 0);
      rst = 1'b0;
      repeat (5) cyc();
      check("rst_no_done", done_cnt, 0);
      fifo.push_back(mk_line(32'hD000));
      start(1'b0, 1, 28'h400);
      run_to_done(60, "rerun");
      check("rerun_done_t", done_t, 18);
      check_writes("rerun", 16, 28'h400, 32'hD000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
